// File: rtl/multicycle_control_pkg.sv
// Shared opcode, writeback-code and trap-cause constants for the multicycle controller.
// Also holds the opcode classification helpers used by the sequencer.
package multicycle_control_pkg;

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [3:0] WB_CODE_NONE   = 4'd0;
    localparam logic [3:0] WB_CODE_ALU    = 4'd1;
    localparam logic [3:0] WB_CODE_LOAD   = 4'd2;
    localparam logic [3:0] WB_CODE_STORE  = 4'd3;
    localparam logic [3:0] WB_CODE_BRANCH = 4'd4;
    localparam logic [3:0] WB_CODE_JAL    = 4'd5;
    localparam logic [3:0] WB_CODE_JALR   = 4'd6;
    localparam logic [3:0] WB_CODE_LUI    = 4'd7;
    localparam logic [3:0] WB_CODE_AUIPC  = 4'd8;
    localparam logic [3:0] WB_CODE_TRAP   = 4'd9;

    localparam logic [1:0] TRAP_CAUSE_ILLEGAL = 2'd0;
    localparam logic [1:0] TRAP_CAUSE_IMEM    = 2'd1;
    localparam logic [1:0] TRAP_CAUSE_DMEM    = 2'd2;

    // SYSTEM is decoded but unsupported (no CSR/ECALL path), so it traps like garbage.
    function automatic logic op_is_illegal(input logic [6:0] op);
        return (op == OPCODE_SYSTEM) ||
               !(op inside {OPCODE_R, OPCODE_I_ALU, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH,
                            OPCODE_JAL, OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC, OPCODE_FENCE});
    endfunction

    function automatic logic op_skips_exec(input logic [6:0] op);
        return op inside {OPCODE_JAL, OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC, OPCODE_FENCE};
    endfunction

    function automatic logic op_is_mem(input logic [6:0] op);
        return (op == OPCODE_LOAD) || (op == OPCODE_STORE);
    endfunction

    function automatic logic op_writes_reg(input logic [6:0] op);
        return op inside {OPCODE_R, OPCODE_I_ALU, OPCODE_LOAD, OPCODE_JAL,
                          OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC};
    endfunction

    function automatic logic [3:0] wb_code_of(input logic [6:0] op, input logic take);
        case (op)
            OPCODE_R, OPCODE_I_ALU: return WB_CODE_ALU;
            OPCODE_LOAD:            return WB_CODE_LOAD;
            OPCODE_STORE:           return WB_CODE_STORE;
            OPCODE_BRANCH:          return take ? WB_CODE_BRANCH : WB_CODE_NONE;
            OPCODE_JAL:             return WB_CODE_JAL;
            OPCODE_JALR:            return WB_CODE_JALR;
            OPCODE_LUI:             return WB_CODE_LUI;
            OPCODE_AUIPC:           return WB_CODE_AUIPC;
            default:                return WB_CODE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle sequencer (master) and the datapath (slave).
interface multicycle_control_if;

    logic       C_IMEM_DONE;
    logic       C_MEM_DONE;
    logic       C_TAKE_BRANCH;
    logic [6:0] OPCODE;
    logic       HALT_REQ;

    logic       C_INSTR_FETCH;
    logic       C_DECODE;
    logic       C_ALU;
    logic       C_CMEM;
    logic       C_DOLOAD;
    logic       C_DOSTORE;
    logic       C_BRANCH;
    logic       C_PC_UPDATE;
    logic       C_REG_AWVALID;
    logic [3:0] C_WB_CODE;
    logic       C_TRAP;
    logic [1:0] C_TRAP_CAUSE;
    logic       HALTED;

    modport master (
        input  C_IMEM_DONE, C_MEM_DONE, C_TAKE_BRANCH, OPCODE, HALT_REQ,
        output C_INSTR_FETCH, C_DECODE, C_ALU, C_CMEM, C_DOLOAD, C_DOSTORE, C_BRANCH,
               C_PC_UPDATE, C_REG_AWVALID, C_WB_CODE, C_TRAP, C_TRAP_CAUSE, HALTED
    );

    modport slave (
        output C_IMEM_DONE, C_MEM_DONE, C_TAKE_BRANCH, OPCODE, HALT_REQ,
        input  C_INSTR_FETCH, C_DECODE, C_ALU, C_CMEM, C_DOLOAD, C_DOSTORE, C_BRANCH,
               C_PC_UPDATE, C_REG_AWVALID, C_WB_CODE, C_TRAP, C_TRAP_CAUSE, HALTED
    );

endinterface

// File: rtl/mctrl_watchdog.sv
// Saturating bus-wait watchdog shared by the fetch and data-memory wait states.
// expired flags the last allowed cycle; a zero limit disables it.
module mctrl_watchdog #(
    parameter int TO_W = 8
) (
    input  logic            CLK,
    input  logic            NRST,
    input  logic            clr,
    input  logic            en,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (limit != '0) && (cnt == limit - 1'b1);

endmodule

// File: rtl/multicycle_control.sv
// RV32I multicycle sequencer: IFETCH/DECODE/EXEC/MEM/WB with bus watchdogs, traps and debug halt.
// Define MCTRL_PERF_CNT_EN to build the cycle/retired-instruction counters.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 16,
    parameter int DMEM_TIMEOUT = 16,
    parameter int TO_W         = 8,
    parameter int CNT_W        = 32
) (
    input  logic                 CLK,
    input  logic                 NRST,
    multicycle_control_if.master bus,
    output logic [CNT_W-1:0]     CYCLE_CNT,
    output logic [CNT_W-1:0]     INSTRET_CNT
);

    typedef enum logic [2:0] {
        S_IFETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_HALT
    } state_e;

    state_e     state;
    logic [1:0] trap_cause_q;
    logic       wd_en;
    logic       wd_expired;
    logic [TO_W-1:0] wd_limit;

    // Only the two bus-wait states count; every other state holds the count at zero,
    // which gives a fresh count on each entry to IFETCH or MEM.
    assign wd_en    = (state == S_IFETCH) || (state == S_MEM);
    assign wd_limit = (state == S_MEM) ? TO_W'(DMEM_TIMEOUT) : TO_W'(IMEM_TIMEOUT);

    mctrl_watchdog #(.TO_W(TO_W)) u_wd (
        .CLK     (CLK),
        .NRST    (NRST),
        .clr     (!wd_en),
        .en      (wd_en),
        .limit   (wd_limit),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state        <= S_IFETCH;
            trap_cause_q <= TRAP_CAUSE_ILLEGAL;
        end else begin
            case (state)
                S_IFETCH: begin
                    if (bus.C_IMEM_DONE) begin
                        state <= S_DECODE;
                    end else if (wd_expired) begin
                        state        <= S_TRAP;
                        trap_cause_q <= TRAP_CAUSE_IMEM;
                    end
                end
                S_DECODE: begin
                    if (op_is_illegal(bus.OPCODE)) begin
                        state        <= S_TRAP;
                        trap_cause_q <= TRAP_CAUSE_ILLEGAL;
                    end else if (op_skips_exec(bus.OPCODE)) begin
                        state <= S_WB;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC:
                    state <= op_is_mem(bus.OPCODE) ? S_MEM : S_WB;
                S_MEM: begin
                    if (bus.C_MEM_DONE) begin
                        state <= S_WB;
                    end else if (wd_expired) begin
                        state        <= S_TRAP;
                        trap_cause_q <= TRAP_CAUSE_DMEM;
                    end
                end
                // Halt is only honoured at an instruction boundary.
                S_WB, S_TRAP:
                    state <= bus.HALT_REQ ? S_HALT : S_IFETCH;
                S_HALT:
                    if (!bus.HALT_REQ) state <= S_IFETCH;
                default:
                    state <= S_IFETCH;
            endcase
        end
    end

    always_comb begin
        bus.C_INSTR_FETCH = 1'b0;
        bus.C_DECODE      = 1'b0;
        bus.C_ALU         = 1'b0;
        bus.C_CMEM        = 1'b0;
        bus.C_DOLOAD      = 1'b0;
        bus.C_DOSTORE     = 1'b0;
        bus.C_BRANCH      = 1'b0;
        bus.C_PC_UPDATE   = 1'b0;
        bus.C_REG_AWVALID = 1'b0;
        bus.C_WB_CODE     = WB_CODE_NONE;
        bus.C_TRAP        = 1'b0;
        case (state)
            S_IFETCH: bus.C_INSTR_FETCH = 1'b1;
            S_DECODE: bus.C_DECODE      = 1'b1;
            S_EXEC: begin
                bus.C_ALU    = (bus.OPCODE == OPCODE_R) || (bus.OPCODE == OPCODE_I_ALU);
                bus.C_CMEM   = op_is_mem(bus.OPCODE);
                bus.C_BRANCH = (bus.OPCODE == OPCODE_BRANCH);
            end
            S_MEM: begin
                bus.C_DOLOAD  = (bus.OPCODE == OPCODE_LOAD);
                bus.C_DOSTORE = (bus.OPCODE == OPCODE_STORE);
            end
            S_WB: begin
                bus.C_PC_UPDATE   = 1'b1;
                bus.C_WB_CODE     = wb_code_of(bus.OPCODE, bus.C_TAKE_BRANCH);
                bus.C_REG_AWVALID = op_writes_reg(bus.OPCODE);
            end
            S_TRAP: begin
                bus.C_TRAP      = 1'b1;
                bus.C_PC_UPDATE = 1'b1;
                bus.C_WB_CODE   = WB_CODE_TRAP;
            end
            default: ;
        endcase
    end

    assign bus.C_TRAP_CAUSE = trap_cause_q;
    assign bus.HALTED       = (state == S_HALT);

`ifdef MCTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state != S_HALT) cycle_q   <= cycle_q + 1'b1;
            if (state == S_WB)   instret_q <= instret_q + 1'b1;
        end
    end

    assign CYCLE_CNT   = cycle_q;
    assign INSTRET_CNT = instret_q;
`else
    assign CYCLE_CNT   = '0;
    assign INSTRET_CNT = '0;
`endif

endmodule
